// File: rtl/hdr_serializer.sv
// hdr_serializer: streams a left-aligned header MSB byte first,
// OUT_BYTES per beat, with valid/ready backpressure and keep/last.
// Ports: clk, rstN (sync, active-low); inValid/inReady/inHdr/inLen
// header input; outValid/outReady/outData/outKeep/outLast beat output;
// busy = header in flight.
// Optional macro HDR_SER_STATS_EN adds hdrCnt (last-beat count) and
// clampErr (sticky, set when inLen > MAX_BYTES is accepted).
module hdr_serializer #(
   parameter int MAX_BYTES = 36,
   parameter int OUT_BYTES = 1,
   parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic [MAX_BYTES*8-1:0] inHdr,
   input  logic [LEN_W-1:0]       inLen,
   output logic                   outValid,
   input  logic                   outReady,
   output logic [OUT_BYTES*8-1:0] outData,
   output logic [OUT_BYTES-1:0]   outKeep,
   output logic                   outLast,
   output logic                   busy
`ifdef HDR_SER_STATS_EN
   ,
   output logic [31:0]            hdrCnt,
   output logic                   clampErr
`endif
);

   localparam int HW = MAX_BYTES * 8;
   localparam int OW = OUT_BYTES * 8;
   localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_BYTES);
   localparam logic [LEN_W-1:0] OBL  = LEN_W'(OUT_BYTES);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state;
   state_t           nxt;
   logic [HW-1:0]    sr;
   logic [LEN_W-1:0] rem;
   logic [LEN_W-1:0] lenc;
   logic             live;
   logic             acc;
   logic             load;
   logic             beat;

   assign lenc = (inLen > MAXL) ? MAXL : inLen;
   assign acc  = inValid & inReady;
   // a zero-length header completes the handshake but loads nothing
   assign load = acc & (inLen != '0);
   assign beat = outValid & outReady;

   // holds inReady low for the first cycle out of reset
   always_ff @(posedge clk) begin
      if (!rstN) live <= 1'b0;
      else       live <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstN) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: if (load) nxt = SEND;
         SEND: if (beat && outLast) nxt = load ? SEND : IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      outValid = 1'b0;
      busy     = 1'b0;
      outLast  = 1'b0;
      outKeep  = '0;
      outData  = '0;
      inReady  = 1'b0;
      if (state == SEND) begin
         outValid = 1'b1;
         busy     = 1'b1;
         outLast  = (rem <= OBL);
         for (int i = 0; i < OUT_BYTES; i++) begin
            // lanes past the header end stay zero
            if (LEN_W'(i) < rem) begin
               outKeep[OUT_BYTES-1-i]  = 1'b1;
               outData[OW-1-8*i -: 8] = sr[HW-1-8*i -: 8];
            end
         end
      end
      inReady = live & ((state == IDLE) |
                        ((state == SEND) & outLast & outReady));
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         sr  <= '0;
         rem <= '0;
      end else if (load) begin
         sr  <= inHdr;
         rem <= lenc;
      end else if (beat) begin
         sr  <= sr << OW;
         rem <= (rem > OBL) ? rem - OBL : '0;
      end
   end

`ifdef HDR_SER_STATS_EN
   always_ff @(posedge clk) begin
      if (!rstN) begin
         hdrCnt   <= '0;
         clampErr <= 1'b0;
      end else begin
         if (beat && outLast) hdrCnt <= hdrCnt + 32'd1;
         if (acc && (inLen > MAXL)) clampErr <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hdr_serializer.sv
// tb_hdr_serializer: randomized self-checking bench for hdr_serializer,
// one instance with 1-byte beats and one with 4-byte beats.
module tb_hdr_serializer;

   logic         clk = 1'b0;
   logic         rstN;
   logic         iv;
   logic         k;
   logic         ordy;
   logic [287:0] hdr;
   logic [5:0]   len;

   logic         iv1, irdy1, ov1, ol1, bsy1;
   logic [7:0]   d1;
   logic [0:0]   kp1;
   logic         iv4, irdy4, ov4, ol4, bsy4;
   logic [31:0]  d4;
   logic [3:0]   kp4;

   logic         s_irdy, s_ov, s_ol, s_bsy;
   logic [31:0]  s_d;
   logic [3:0]   s_kp;

   int checks = 0;
   int errors = 0;

`ifdef HDR_SER_STATS_EN
   logic [31:0] hc1, hc4;
   logic        ce1, ce4;
`endif

   always #5 clk = ~clk;

   assign iv1 = iv & ~k;
   assign iv4 = iv & k;

   always_comb begin
      s_irdy = k ? irdy4 : irdy1;
      s_ov   = k ? ov4 : ov1;
      s_ol   = k ? ol4 : ol1;
      s_bsy  = k ? bsy4 : bsy1;
      s_d    = k ? d4 : {24'b0, d1};
      s_kp   = k ? kp4 : {3'b0, kp1};
   end

   hdr_serializer #(.MAX_BYTES(36), .OUT_BYTES(1)) u1 (
      .clk(clk), .rstN(rstN), .inValid(iv1), .inReady(irdy1),
      .inHdr(hdr), .inLen(len), .outValid(ov1), .outReady(ordy),
      .outData(d1), .outKeep(kp1), .outLast(ol1), .busy(bsy1)
`ifdef HDR_SER_STATS_EN
      , .hdrCnt(hc1), .clampErr(ce1)
`endif
   );

   hdr_serializer #(.MAX_BYTES(36), .OUT_BYTES(4)) u4 (
      .clk(clk), .rstN(rstN), .inValid(iv4), .inReady(irdy4),
      .inHdr(hdr), .inLen(len), .outValid(ov4), .outReady(ordy),
      .outData(d4), .outKeep(kp4), .outLast(ol4), .busy(bsy4)
`ifdef HDR_SER_STATS_EN
      , .hdrCnt(hc4), .clampErr(ce4)
`endif
   );

   function automatic logic [287:0] rnd288();
      return {$urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [287:0] eth_hdr();
      logic [287:0] h;
      h = rnd288();
      h[287 -: 112] = {48'h001122334455, 48'hAABBCCDDEEFF, 16'h0800};
      return h;
   endfunction

   // Offers one header, then checks every beat against a byte queue.
   task automatic send_frame(input logic [287:0] h, input int l,
                             input int pct, output int beats);
      logic [7:0]  q[$];
      logic [31:0] ed;
      logic [3:0]  ek;
      logic        el;
      int nl, ob, cyc, n;
      nl = (l > 36) ? 36 : l;
      ob = k ? 4 : 1;
      beats = 0;
      for (int i = 0; i < nl; i++) q.push_back(h[287-8*i -: 8]);
      @(negedge clk);
      hdr = h; len = 6'(l); iv = 1'b1;
      cyc = 0;
      while (!s_irdy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (s_irdy !== 1'b1) begin
         errors++;
         $display("FAIL accept: inReady=%b required 1", s_irdy);
         iv = 1'b0;
         return;
      end
      @(negedge clk);
      iv = 1'b0; hdr = rnd288(); len = 6'($urandom_range(63));
      cyc = 0;
      while (q.size() > 0 && cyc < 2000) begin
         checks++;
         if (s_ov !== 1'b1) begin
            errors++;
            $display("FAIL beat_valid: outValid=%b required 1 (beat %0d)",
                     s_ov, beats);
            break;
         end
         n = (q.size() < ob) ? q.size() : ob;
         ed = '0; ek = '0;
         for (int j = 0; j < n; j++) begin
            ed[(ob-j)*8-1 -: 8] = q[j];
            ek[ob-1-j] = 1'b1;
         end
         el = (q.size() <= ob);
         checks++;
         if (s_d !== ed || s_kp !== ek || s_ol !== el || s_bsy !== 1'b1)
            begin
            errors++;
            $display("FAIL beat %0d: data=%h keep=%b last=%b busy=%b required data=%h keep=%b last=%b busy=1",
                     beats, s_d, s_kp, s_ol, s_bsy, ed, ek, el);
         end
         ordy = ($urandom_range(99) < pct);
         if (ordy) begin
            for (int j = 0; j < n; j++) void'(q.pop_front());
            beats++;
         end
         @(negedge clk);
         cyc++;
      end
      ordy = 1'b1;
      checks++;
      if (s_ov !== 1'b0 || s_bsy !== 1'b0) begin
         errors++;
         $display("FAIL frame_end: outValid=%b busy=%b required 0 0",
                  s_ov, s_bsy);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstN = 1'b0; iv = 1'b0; ordy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      k = 1'b0; iv = 1'b0; ordy = 1'b1; hdr = '0; len = '0;
      rstN = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({irdy1, ov1, ol1, bsy1, d1, kp1} !== '0 ||
          {irdy4, ov4, ol4, bsy4, d4, kp4} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: u1=%b%b%b%b %h %b u4=%b%b%b%b %h %b required all 0",
                  irdy1, ov1, ol1, bsy1, d1, kp1,
                  irdy4, ov4, ol4, bsy4, d4, kp4);
      end
`ifdef HDR_SER_STATS_EN
      checks++;
      if (hc1 !== 32'd0 || ce1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_stats: hdrCnt=%0d clampErr=%b required 0 0",
                  hc1, ce1);
      end
`endif
      rstN = 1'b1;
      @(negedge clk);
      checks++;
      if (irdy1 !== 1'b1 || irdy4 !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: inReady=%b %b required 1 1",
                  irdy1, irdy4);
      end
   endtask

   task automatic test_eth(input logic sel);
      int b;
      k = sel;
      send_frame(eth_hdr(), 14, 100, b);
      checks++;
      if (b !== (sel ? 4 : 14)) begin
         errors++;
         $display("FAIL eth_beats: beats=%0d required %0d",
                  b, sel ? 4 : 14);
      end
   endtask

   task automatic test_backpressure(input logic sel);
      int b;
      k = sel;
      send_frame(rnd288(), 20, 50, b);
      checks++;
      if (b !== (sel ? 5 : 20)) begin
         errors++;
         $display("FAIL bp_beats: beats=%0d required %0d",
                  b, sel ? 5 : 20);
      end
   endtask

   task automatic test_back_to_back();
      logic [287:0] hu, hm;
      logic [7:0]   q[$];
      logic         el, er;
      k = 1'b0; ordy = 1'b1;
      hu = rnd288(); hm = rnd288();
      for (int i = 0; i < 8; i++) q.push_back(hu[287-8*i -: 8]);
      for (int i = 0; i < 22; i++) q.push_back(hm[287-8*i -: 8]);
      @(negedge clk);
      hdr = hu; len = 6'd8; iv = 1'b1;
      checks++;
      if (irdy1 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready: inReady=%b required 1", irdy1);
      end
      @(negedge clk);
      hdr = hm; len = 6'd22;
      for (int i = 1; i <= 30; i++) begin
         if (i == 9) iv = 1'b0;
         el = (i == 8) || (i == 30);
         er = el;
         checks++;
         if (ov1 !== 1'b1 || d1 !== q[i-1] || ol1 !== el || irdy1 !== er)
            begin
            errors++;
            $display("FAIL b2b beat %0d: valid=%b data=%h last=%b ready=%b required 1 %h %b %b",
                     i, ov1, d1, ol1, irdy1, q[i-1], el, er);
         end
         @(negedge clk);
      end
      checks++;
      if (ov1 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: outValid=%b required 0", ov1);
      end
   endtask

   task automatic test_len0();
`ifdef HDR_SER_STATS_EN
      logic [31:0] c0;
      c0 = hc1;
`endif
      k = 1'b0;
      @(negedge clk);
      hdr = rnd288(); len = 6'd0; iv = 1'b1;
      checks++;
      if (irdy1 !== 1'b1) begin
         errors++;
         $display("FAIL len0_ready: inReady=%b required 1", irdy1);
      end
      @(negedge clk);
      iv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (ov1 !== 1'b0 || bsy1 !== 1'b0 || irdy1 !== 1'b1) begin
            errors++;
            $display("FAIL len0_idle: valid=%b busy=%b ready=%b required 0 0 1",
                     ov1, bsy1, irdy1);
         end
         @(negedge clk);
      end
`ifdef HDR_SER_STATS_EN
      checks++;
      if (hc1 !== c0) begin
         errors++;
         $display("FAIL len0_cnt: hdrCnt=%0d required %0d", hc1, c0);
      end
`endif
   endtask

   task automatic test_clamp();
      int b;
      do_reset();
      k = 1'b0;
      send_frame(rnd288(), 40, 100, b);
      checks++;
      if (b !== 36) begin
         errors++;
         $display("FAIL clamp_beats: beats=%0d required 36", b);
      end
`ifdef HDR_SER_STATS_EN
      checks++;
      if (ce1 !== 1'b1 || hc1 !== 32'd1) begin
         errors++;
         $display("FAIL clamp_stats: clampErr=%b hdrCnt=%0d required 1 1",
                  ce1, hc1);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [287:0] h;
      int b;
      k = 1'b0; ordy = 1'b1;
      h = rnd288();
      @(negedge clk);
      hdr = h; len = 6'd36; iv = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         checks++;
         if (ov1 !== 1'b1 || d1 !== h[287-8*(i-1) -: 8]) begin
            errors++;
            $display("FAIL mid beat %0d: valid=%b data=%h required 1 %h",
                     i, ov1, d1, h[287-8*(i-1) -: 8]);
         end
         if (i == 5) rstN = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (ov1 !== 1'b0 || bsy1 !== 1'b0 || ol1 !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: valid=%b busy=%b last=%b required 0 0 0",
                  ov1, bsy1, ol1);
      end
      rstN = 1'b1;
      @(negedge clk);
      send_frame(rnd288(), 36, 100, b);
      checks++;
      if (b !== 36) begin
         errors++;
         $display("FAIL mid_after: beats=%0d required 36", b);
      end
   endtask

   task automatic test_random();
      int b, l, p, exp;
      for (int t = 0; t < 12; t++) begin
         k = 1'($urandom_range(1));
         l = $urandom_range(40, 1);
         p = $urandom_range(100, 30);
         send_frame(rnd288(), l, p, b);
         exp = k ? ((l > 36 ? 36 : l) + 3) / 4 : (l > 36 ? 36 : l);
         checks++;
         if (b !== exp) begin
            errors++;
            $display("FAIL rand_beats: len=%0d beats=%0d required %0d",
                     l, b, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_eth(1'b0);
      test_eth(1'b1);
      test_backpressure(1'b0);
      test_backpressure(1'b1);
      test_back_to_back();
      test_len0();
      test_clamp();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

endmodule
